// File: rtl/mips_alu_pkg.sv
// Shared constants and types for the MIPS ALU operand/control issue stage:
// ALU control codes, opcode/funct values, issue FSM states and the decoded bundle.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b0101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        illegal;
    } alu_bundle_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of a MIPS instruction plus rs/rt values into the
// ALU operand/control bundle (operand B selection and immediate extension).
module alu_op_decode
    import mips_alu_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output alu_bundle_t bundle
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext = {16'h0000, instr[15:0]};

    always_comb begin
        // Undecodable instructions still carry A=rs, B=rt so the bundle is fully defined.
        bundle.a       = rs_data;
        bundle.b       = rt_data;
        bundle.ctrl    = ILLEGAL_CTRL;
        bundle.illegal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                bundle.illegal = 1'b0;
                case (funct)
                    FN_ADD, FN_ADDU: bundle.ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: bundle.ctrl = ALU_SUB;
                    FN_AND:          bundle.ctrl = ALU_AND;
                    FN_OR:           bundle.ctrl = ALU_OR;
                    FN_NOR:          bundle.ctrl = ALU_NOR;
                    FN_SLT:          bundle.ctrl = ALU_SLT;
                    default: begin
                        bundle.ctrl    = ILLEGAL_CTRL;
                        bundle.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                bundle.ctrl    = ALU_ADD;
                bundle.b       = imm_sext;
                bundle.illegal = 1'b0;
            end
            OP_SLTI: begin
                bundle.ctrl    = ALU_SLT;
                bundle.b       = imm_sext;
                bundle.illegal = 1'b0;
            end
            OP_ANDI: begin
                bundle.ctrl    = ALU_AND;
                bundle.b       = imm_zext;
                bundle.illegal = 1'b0;
            end
            OP_ORI: begin
                bundle.ctrl    = ALU_OR;
                bundle.b       = imm_zext;
                bundle.illegal = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                // Branch compare: subtract rt from rs, zero flag decides.
                bundle.ctrl    = ALU_SUB;
                bundle.illegal = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// ALU operand/control issue stage: decodes incoming instructions and presents a
// registered bundle over valid/ready, with a 1-entry skid so in_ready is a flop.
module alu_op_issue
    import mips_alu_pkg::*;
#(
    parameter int         CNT_W        = 8,
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs_data,
    input  logic [31:0]      in_rt_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      alu_input_0,
    output logic [31:0]      alu_input_1,
    output logic [3:0]       alu_control,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    alu_bundle_t  dec_bundle;
    alu_bundle_t  out_reg;
    alu_bundle_t  skid_reg;
    issue_state_t state_reg, state_next;
    logic         in_ready_reg, in_ready_next;
    logic         load_out_from_in, load_out_from_skid, load_skid;
    logic         in_xfer, out_xfer;
    logic [CNT_W-1:0] count_reg;

    alu_op_decode #(
        .ILLEGAL_CTRL(ILLEGAL_CTRL)
    ) u_decode (
        .instr  (in_instr),
        .rs_data(in_rs_data),
        .rt_data(in_rt_data),
        .bundle (dec_bundle)
    );

    assign in_xfer  = in_valid & in_ready_reg;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_next         = state_reg;
        in_ready_next      = in_ready_reg;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_next       = ST_ONE;
                    load_out_from_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out_from_in = 1'b1;
                end else if (in_xfer) begin
                    state_next    = ST_TWO;
                    load_skid     = 1'b1;
                    in_ready_next = 1'b0;
                end else if (out_xfer) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Skid always holds the younger entry, so it refills the output on drain.
                if (out_xfer) begin
                    state_next         = ST_ONE;
                    load_out_from_skid = 1'b1;
                    in_ready_next      = 1'b1;
                end
            end
            default: begin
                state_next    = ST_EMPTY;
                in_ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b1;
            out_reg      <= '0;
            skid_reg     <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= in_ready_next;
            if (load_out_from_in) begin
                out_reg <= dec_bundle;
            end else if (load_out_from_skid) begin
                out_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= dec_bundle;
            end
            if (out_xfer && out_reg.illegal && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_valid     = (state_reg != ST_EMPTY);
    assign alu_input_0   = out_reg.a;
    assign alu_input_1   = out_reg.b;
    assign alu_control   = out_reg.ctrl;
    assign out_illegal   = out_reg.illegal;
    assign illegal_count = count_reg;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue: decode, stalls/skid ordering,
// illegal counter saturation and asynchronous mid-operation reset.
module tb_alu_op_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_input_0;
    logic [31:0] alu_input_1;
    logic [3:0]  alu_control;
    logic        out_illegal;
    logic [7:0]  illegal_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_op_issue #(
        .CNT_W       (8),
        .ILLEGAL_CTRL(4'b1111)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_rs_data   (in_rs_data),
        .in_rt_data   (in_rt_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_input_0  (alu_input_0),
        .alu_input_1  (alu_input_1),
        .alu_control  (alu_control),
        .out_illegal  (out_illegal),
        .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [5:0] funct);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // Advance one active edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction with out_ready=1 and check the bundle the cycle after.
    task automatic issue_check(input string name, input logic [31:0] instr,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [3:0] exp_ctrl, input logic [31:0] exp_b,
                               input logic exp_ill);
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_instr   = instr;
        in_rs_data = rs;
        in_rt_data = rt;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || alu_control !== exp_ctrl || alu_input_0 !== rs ||
            alu_input_1 !== exp_b || out_illegal !== exp_ill)
            $display("FAIL %s: got v=%b ctrl=%b A=%h B=%h ill=%b want v=1 ctrl=%b A=%h B=%h ill=%b",
                     name, out_valid, alu_control, alu_input_0, alu_input_1, out_illegal,
                     exp_ctrl, rs, exp_b, exp_ill);
        else begin
            pass_cnt++;
            $display("txn %s ctrl=%b A=%h B=%h ill=%b", name, alu_control, alu_input_0,
                     alu_input_1, out_illegal);
        end
        step();
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL %s_drain: got out_valid=%b want 0", name, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs_data = '0; in_rt_data = '0;
        #12;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_input_0 !== 32'h0 ||
            alu_input_1 !== 32'h0 || alu_control !== 4'b0000 || out_illegal !== 1'b0 ||
            illegal_count !== 8'd0)
            $display("FAIL reset: got v=%b rdy=%b A=%h B=%h ctrl=%b ill=%b cnt=%0d want 0 1 0 0 0000 0 0",
                     out_valid, in_ready, alu_input_0, alu_input_1, alu_control,
                     out_illegal, illegal_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        issue_check("add", rtype(6'h20), 32'h3, 32'hFFFF_FFFF, 4'b0010, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_imm();
        issue_check("addi", itype(6'h08, 16'hFFFC), 32'h10, 32'h55, 4'b0010, 32'hFFFF_FFFC, 1'b0);
        issue_check("ori",  itype(6'h0D, 16'hFFFC), 32'h10, 32'h55, 4'b0001, 32'h0000_FFFC, 1'b0);
        issue_check("andi", itype(6'h0C, 16'h8001), 32'h7, 32'h55, 4'b0000, 32'h0000_8001, 1'b0);
        issue_check("sw",   itype(6'h2B, 16'h8000), 32'h100, 32'h55, 4'b0010, 32'hFFFF_8000, 1'b0);
        issue_check("slti", itype(6'h0A, 16'hFFFF), 32'h2, 32'h55, 4'b0111, 32'hFFFF_FFFF, 1'b0);
        issue_check("nor",  rtype(6'h27), 32'hF0, 32'h0F, 4'b0101, 32'h0F, 1'b0);
        issue_check("subu", rtype(6'h23), 32'h9, 32'h4, 4'b0110, 32'h4, 1'b0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = rtype(6'h20); in_rs_data = 32'hA1; in_rt_data = 32'hB1;
        step();
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || alu_input_0 !== 32'hA1 || alu_control !== 4'b0010)
            $display("FAIL b2b_first: got rdy=%b v=%b A=%h ctrl=%b want 1 1 a1 0010",
                     in_ready, out_valid, alu_input_0, alu_control);
        else pass_cnt++;
        in_instr = rtype(6'h22); in_rs_data = 32'hA2; in_rt_data = 32'hB2;
        step();
        total_cnt++;
        if (in_ready !== 1'b0 || alu_input_0 !== 32'hA1)
            $display("FAIL b2b_full: got rdy=%b A=%h want 0 a1", in_ready, alu_input_0);
        else pass_cnt++;
        in_instr = rtype(6'h24); in_rs_data = 32'hA3; in_rt_data = 32'hB3;
        step();
        step();
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_input_0 !== 32'hA1 ||
            alu_input_1 !== 32'hB1 || alu_control !== 4'b0010)
            $display("FAIL b2b_stall: got rdy=%b v=%b A=%h B=%h ctrl=%b want 0 1 a1 b1 0010",
                     in_ready, out_valid, alu_input_0, alu_input_1, alu_control);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || alu_input_0 !== 32'hA2 ||
            alu_input_1 !== 32'hB2 || alu_control !== 4'b0110)
            $display("FAIL b2b_second: got rdy=%b v=%b A=%h B=%h ctrl=%b want 1 1 a2 b2 0110",
                     in_ready, out_valid, alu_input_0, alu_input_1, alu_control);
        else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || alu_input_0 !== 32'hA3 || alu_input_1 !== 32'hB3 ||
            alu_control !== 4'b0000)
            $display("FAIL b2b_third: got v=%b A=%h B=%h ctrl=%b want 1 a3 b3 0000",
                     out_valid, alu_input_0, alu_input_1, alu_control);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
        else pass_cnt++;
        $display("txn back_to_back done");
    endtask

    task automatic test_illegal();
        issue_check("bad_funct", rtype(6'h00), 32'h11, 32'h22, 4'b1111, 32'h22, 1'b1);
        total_cnt++;
        if (illegal_count !== 8'd1)
            $display("FAIL ill_count1: got %0d want 1", illegal_count);
        else pass_cnt++;
        // Stream op 0x3F continuously; after edge k, k illegal bundles have been consumed
        // counting the earlier one.
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = itype(6'h3F, 16'h1234); in_rs_data = 32'h33; in_rt_data = 32'h44;
        for (int k = 1; k <= 257; k++) begin
            step();
            if (k == 1) begin
                total_cnt++;
                if (alu_control !== 4'b1111 || out_illegal !== 1'b1 ||
                    alu_input_0 !== 32'h33 || alu_input_1 !== 32'h44)
                    $display("FAIL ill_op: got ctrl=%b ill=%b A=%h B=%h want 1111 1 33 44",
                             alu_control, out_illegal, alu_input_0, alu_input_1);
                else pass_cnt++;
            end
            if (k == 200) begin
                total_cnt++;
                if (illegal_count !== 8'd200)
                    $display("FAIL ill_count200: got %0d want 200", illegal_count);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (illegal_count !== 8'd255 || out_valid !== 1'b0)
            $display("FAIL ill_saturate: got cnt=%0d v=%b want 255 0", illegal_count, out_valid);
        else pass_cnt++;
        $display("txn illegal count=%0d", illegal_count);
    endtask

    task automatic test_branch_slt();
        logic [31:0] diff;
        logic        lt;
        issue_check("beq", itype(6'h04, 16'h0010), 32'h5, 32'h5, 4'b0110, 32'h5, 1'b0);
        issue_check("bne", itype(6'h05, 16'h0010), 32'h5, 32'h6, 4'b0110, 32'h6, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = itype(6'h04, 16'h0020); in_rs_data = 32'h5; in_rt_data = 32'h5;
        step();
        in_valid = 1'b0;
        diff = alu_input_0 - alu_input_1;
        total_cnt++;
        if (diff !== 32'h0 || alu_control !== 4'b0110)
            $display("FAIL beq_zero: got diff=%h ctrl=%b want 0 0110", diff, alu_control);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = rtype(6'h2A); in_rs_data = 32'hFFFF_FFFF; in_rt_data = 32'h1;
        step();
        in_valid = 1'b0;
        lt = ($signed(alu_input_0) < $signed(alu_input_1));
        total_cnt++;
        if (lt !== 1'b1 || alu_control !== 4'b0111 || alu_input_1 !== 32'h1)
            $display("FAIL slt_result: got lt=%b ctrl=%b B=%h want 1 0111 1", lt, alu_control, alu_input_1);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        $display("txn branch_slt done");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = rtype(6'h25); in_rs_data = 32'hC1; in_rt_data = 32'hD1;
        step();
        in_rs_data = 32'hC2;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL mid_two: got rdy=%b v=%b want 0 1", in_ready, out_valid);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 8'd0)
            $display("FAIL mid_async: got v=%b rdy=%b cnt=%0d want 0 1 0", out_valid, in_ready, illegal_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL mid_stale%0d: got out_valid=%b want 0", i, out_valid);
            else pass_cnt++;
        end
        issue_check("post_reset_or", rtype(6'h25), 32'hE1, 32'hE2, 4'b0001, 32'hE2, 1'b0);
        $display("txn reset_mid done");
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_back_to_back();
        test_illegal();
        test_branch_slt();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
